// File: rtl/writeback_commit_queue_if.sv
`default_nettype none
// ============================================================================
// writeback_commit_queue_if
// Retire-bundle input, register-file write ports and commit-queue drain port.
// Revision: 1.0
// ============================================================================
interface writeback_commit_queue_if #(
    parameter int NUM_WAYS = 2,
    parameter int DEPTH    = 8,
    parameter int XLEN     = 64
);
    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_WAYS-1:0]          in_lane_valid;
    logic [5*NUM_WAYS-1:0]        in_reg_dest_addr;
    logic [NUM_WAYS-1:0]          in_reg_write_enable;
    logic [XLEN*NUM_WAYS-1:0]     in_reg_write_data;
    logic [32*NUM_WAYS-1:0]       in_inst;
    logic [XLEN*NUM_WAYS-1:0]     in_inst_pc;

    logic [NUM_WAYS-1:0]          rf_write_enable;
    logic [5*NUM_WAYS-1:0]        rf_dest_addr;
    logic [XLEN*NUM_WAYS-1:0]     rf_write_data;

    logic                         out_valid;
    logic                         out_ready;
    logic [4:0]                   out_reg_dest_addr;
    logic                         out_reg_write_enable;
    logic [XLEN-1:0]              out_reg_write_data;
    logic [31:0]                  out_inst;
    logic [XLEN-1:0]              out_inst_pc;

    logic [$clog2(DEPTH):0]       occupancy;
    logic [63:0]                  commit_count;
    logic                         ok;

    modport slave (
        input  in_valid, in_lane_valid, in_reg_dest_addr, in_reg_write_enable,
               in_reg_write_data, in_inst, in_inst_pc, out_ready,
        output in_ready, rf_write_enable, rf_dest_addr, rf_write_data,
               out_valid, out_reg_dest_addr, out_reg_write_enable,
               out_reg_write_data, out_inst, out_inst_pc,
               occupancy, commit_count, ok
    );

    modport master (
        output in_valid, in_lane_valid, in_reg_dest_addr, in_reg_write_enable,
               in_reg_write_data, in_inst, in_inst_pc, out_ready,
        input  in_ready, rf_write_enable, rf_dest_addr, rf_write_data,
               out_valid, out_reg_dest_addr, out_reg_write_enable,
               out_reg_write_data, out_inst, out_inst_pc,
               occupancy, commit_count, ok
    );
endinterface
`default_nettype wire

// File: rtl/writeback_commit_queue.sv
`default_nettype none
// ============================================================================
// writeback_commit_queue
// Multi-lane writeback: RF write ports plus an in-order commit record queue.
// Revision: 1.0
// ============================================================================
module writeback_commit_queue #(
    parameter int NUM_WAYS = 2,
    parameter int DEPTH    = 8,
    parameter int XLEN     = 64
) (
    input  wire logic               clk,
    input  wire logic               reset,
    writeback_commit_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [63:0]      commit_count_q, commit_count_d;

    logic [4:0]       mem_dest_q [DEPTH];
    logic             mem_we_q   [DEPTH];
    logic [XLEN-1:0]  mem_data_q [DEPTH];
    logic [31:0]      mem_inst_q [DEPTH];
    logic [XLEN-1:0]  mem_pc_q   [DEPTH];

    logic                w_ready;
    logic                w_accept;
    logic                w_pop;
    logic [NUM_WAYS-1:0] w_base;
    logic [NUM_WAYS-1:0] w_rf_we;
    logic [OCC_W-1:0]    w_cnt;
    logic [OCC_W-1:0]    w_pushed;
    logic [PTR_W-1:0]    w_slot [NUM_WAYS];

    // Ready looks only at registered occupancy, so a same-cycle pop never feeds back.
    assign w_ready  = reset && ((OCC_W'(DEPTH) - occ_q) >= OCC_W'(NUM_WAYS));
    assign w_accept = bus.in_valid && w_ready;
    assign w_pop    = (occ_q != '0) && bus.out_ready;

    // Valid lanes are packed into consecutive tail slots in lane order.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            w_base[i] = w_accept && bus.in_lane_valid[i] && bus.in_reg_write_enable[i]
                        && (bus.in_reg_dest_addr[5*i +: 5] != 5'd0);
            w_slot[i] = tail_q + PTR_W'(w_cnt);
            if (bus.in_lane_valid[i]) begin
                w_cnt = w_cnt + OCC_W'(1);
            end
        end
        w_pushed = w_accept ? w_cnt : '0;
    end

    // Youngest lane wins when several lanes write the same register.
    always_comb begin
        w_rf_we = w_base;
        for (int i = 0; i < NUM_WAYS; i++) begin
            for (int j = i + 1; j < NUM_WAYS; j++) begin
                if (w_base[j] && (bus.in_reg_dest_addr[5*j +: 5] == bus.in_reg_dest_addr[5*i +: 5])) begin
                    w_rf_we[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        tail_d         = tail_q + PTR_W'(w_pushed);
        head_d         = head_q + PTR_W'(w_pop);
        occ_d          = occ_q + w_pushed - OCC_W'(w_pop);
        commit_count_d = commit_count_q + 64'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            occ_q          <= '0;
            commit_count_q <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            occ_q          <= occ_d;
            commit_count_q <= commit_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (bus.in_lane_valid[i]) begin
                    mem_dest_q[w_slot[i]] <= bus.in_reg_dest_addr[5*i +: 5];
                    mem_we_q[w_slot[i]]   <= bus.in_reg_write_enable[i];
                    mem_data_q[w_slot[i]] <= bus.in_reg_write_data[XLEN*i +: XLEN];
                    mem_inst_q[w_slot[i]] <= bus.in_inst[32*i +: 32];
                    mem_pc_q[w_slot[i]]   <= bus.in_inst_pc[XLEN*i +: XLEN];
                end
            end
        end
    end

    assign bus.in_ready             = w_ready;
    assign bus.ok                   = w_ready;
    assign bus.rf_write_enable      = w_rf_we;
    assign bus.rf_dest_addr         = bus.in_reg_dest_addr;
    assign bus.rf_write_data        = bus.in_reg_write_data;
    assign bus.out_valid            = (occ_q != '0);
    assign bus.out_reg_dest_addr    = mem_dest_q[head_q];
    assign bus.out_reg_write_enable = mem_we_q[head_q];
    assign bus.out_reg_write_data   = mem_data_q[head_q];
    assign bus.out_inst             = mem_inst_q[head_q];
    assign bus.out_inst_pc          = mem_pc_q[head_q];
    assign bus.occupancy            = occ_q;
    assign bus.commit_count         = commit_count_q;
endmodule
`default_nettype wire
